// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage helpers.
package cpu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

  localparam int MUL_WIDTH = 32;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Shift-add unsigned multiply sequencer; borrows the shared EX-stage adder
// for one add per cycle and hands back a 2*WIDTH product with a done pulse.
module mul_seq_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               flush,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_t       state;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mc;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // Adder inputs are parked at zero outside RUN so the shared adder stays quiet.
  assign add_a = (state == RUN) ? hi : '0;
  assign add_b = (state == RUN && lo[0]) ? mc : '0;

  // Carry enters hi from the top; the adder LSB slides into lo as lo[0] retires.
  assign hi_next = {add_cout, add_sum[WIDTH-1:1]};
  assign lo_next = {add_sum[0], lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      hi      <= '0;
      lo      <= '0;
      mc      <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mc    <= mcand;
              hi    <= '0;
              lo    <= mplier;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
          RUN: begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              product <= {hi_next, lo_next};
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench for mul_seq_ctrl with a behavioural model of the shared adder.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int vec_cnt  = 0;
  int err_cnt  = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  // Stand-in for the shared carry-lookahead adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  mul_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .flush    (flush),
    .mcand    (mcand),
    .mplier   (mplier),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .busy     (busy),
    .done     (done),
    .product  (product)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%016h", tag, got);
    end
  endtask

  // Caller sits just after a negedge. side_k injects a start while busy,
  // flush_k pulses flush on that RUN cycle; zero_b checks add_b stays 0.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         input int side_k, input int flush_k, input bit zero_b);
    logic [63:0] prev_product;
    logic [63:0] exp;
    int          busy_n;
    int          addb_nz;
    int          late_done;
    bit          finished;
    prev_product = product;
    busy_n       = 0;
    addb_nz      = 0;
    finished     = 1'b0;
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk);
    sb_q.push_back({32'd0, a} * {32'd0, b});
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      if (flush_k > 0 && k == flush_k + 1) begin
        check("flush_busy_done", {62'd0, busy, done}, 64'd0);
        check("flush_hold_product", product, prev_product);
        exp = sb_q.pop_front();
        late_done = 0;
        for (int j = 0; j < 25; j++) begin
          @(negedge clk);
          if (done) late_done++;
        end
        check("flush_no_done", 64'(late_done), 64'd0);
        finished = 1'b1;
        break;
      end
      if (busy) busy_n++;
      if (busy && add_b != 32'd0) addb_nz++;
      if (done) begin
        check("latency", 64'(k), 64'd33);
        check("busy_cycles", 64'(busy_n), 64'd32);
        exp = sb_q.pop_front();
        check($sformatf("product_%0h_x_%0h", a, b), product, exp);
        if (zero_b) check("zero_addb", 64'(addb_nz), 64'd0);
        @(negedge clk);
        check("done_pulse", {62'd0, busy, done}, 64'd0);
        check("product_held", product, exp);
        finished = 1'b1;
        break;
      end
      if (k == side_k) begin
        start  = 1'b1;
        mcand  = 32'd2;
        mplier = 32'd2;
      end
      if (k == flush_k) flush = 1'b1;
    end
    if (!finished) begin
      check("done_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    reset  = 1'b1;
    start  = 1'b0;
    flush  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, 30'd0, add_a | add_b}, 64'd0);
    check("reset_product", product, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_mul(32'd3, 32'd5, 0, 0, 1'b0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_mul(32'h1234_5678, 32'd0, 0, 0, 1'b1);
    run_mul(32'd7, 32'd6, 10, 0, 1'b0);
    run_mul(32'd9, 32'd9, 0, 15, 1'b0);
    run_mul(32'd4, 32'd4, 0, 0, 1'b0);

    // start together with flush in IDLE must be dropped
    start = 1'b1;
    flush = 1'b1;
    mcand = 32'd11;
    mplier = 32'd11;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_drops_start", {63'd0, busy}, 64'd0);
    @(negedge clk);

    // asynchronous reset between edges in the middle of RUN
    start  = 1'b1;
    mcand  = 32'd5;
    mplier = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_flags", {62'd0, busy, done}, 64'd0);
    check("async_reset_product", product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_mul(32'd2, 32'd3, 0, 0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_mul(ra, rb, 0, 0, 1'b0);
    end

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
